mcu_spi_regbank: RTL and testbench
==================================

// Module: mcu_spi_regbank
// PURPOSE
// - Parametrised MCU SPI-slave register bank for the S7 board controller. Replaces the single-bit SPI echo on MCU_SPI1/2.
// - Oversamples SCK/NSS/MOSI on the system clock and decodes framed read/write commands.
// - Exposes NUM_CTRL read/write control words, NUM_STAT read-only status words and one ID word.
// - Supports burst transfers with address auto-increment.
// PARAMETERS
// DATA_W     32              data word width, bits; legal range 8..32
// NUM_CTRL   8               number of R/W control registers; legal range 1..63
// NUM_STAT   4               number of read-only status registers; legal range 1..64
// ID_WORD    32'h1911_0100   value read at address 0x00 (build date); truncated to DATA_W
// CTRL_RST   0               reset value of every control register
// PORTS
// clk          in   1                  system clock; f_clk >= 8 x f_sck
// rst_b        in   1                  asynchronous active-low reset
// spi_sck      in   1                  MCU SPI clock, mode 0 (CPOL=0, CPHA=0); async to clk
// spi_nss      in   1                  MCU SPI chip select, active low; async to clk
// spi_mosi     in   1                  MCU to FPGA serial data, MSB first
// spi_miso     out  1                  FPGA to MCU serial data, MSB first
// spi_miso_oe  out  1                  MISO output enable; 1 while a frame is selected
// ctrl_q       out  NUM_CTRL*DATA_W    control registers; word k at [k*DATA_W +: DATA_W]
// wr_stb       out  NUM_CTRL           1-clk pulse on bit k when ctrl word k is written
// stat_d       in   NUM_STAT*DATA_W    status inputs; word k at [k*DATA_W +: DATA_W]
// busy         out  1                  1 while a frame is in progress (state != IDLE)
// BEHAVIOUR
// - Input synchronisers: 2-FF synchroniser on sck, nss and mosi, plus a third stage for edge detection.
//   - sck_rise / sck_fall / nss_fall / nss_rise are 1-clk pulses derived from the synchronised signals.
// - Reset values: ctrl_q = CTRL_RST; wr_stb = 0; spi_miso = 0; spi_miso_oe = 0; busy = 0; FSM = IDLE.
// - Frame format: [CMD 8b][DATA_W b][DATA_W b]...
//   - CMD[7] = 1 for read, 0 for write. CMD[6:0] = start address.
// - Address map:
//   - 0x00: ID_WORD, read-only.
//   - 0x01..NUM_CTRL: ctrl word (addr-1).
//   - 0x40..0x40+NUM_STAT-1: stat word (addr-0x40).
//   - Anything else is unmapped: reads return 0, writes are ignored.
// - FSM:
//   - IDLE -> CMD on nss_fall. bit_cnt = 0. spi_miso_oe = 1.
//   - CMD: shift mosi on each sck_rise. After the 8th bit, latch rw/addr and go to DATA.
//     - For a read, load shift_reg with the word at addr on the same clk.
//     - spi_miso = 0 throughout CMD.
//   - DATA: spi_miso = shift_reg MSB, updated on sck_fall; shift in mosi on sck_rise.
//     - After the DATA_W-th bit of a write to a ctrl address:
//       - ctrl word is updated on the next clk.
//       - the matching wr_stb bit pulses for exactly that clk.
//     - After each DATA_W-th bit: addr <= addr+1 (7-bit, 0x7F wraps to 0x00).
//       - For a read, reload shift_reg from the new addr (burst).
//   - Any state -> IDLE on nss_rise (priority over a coincident sck edge).
//     - Partial word is discarded: no write, no strobe.
//     - spi_miso_oe = 0 and spi_miso = 0 on the next clk.
// - Status words are snapshotted when loaded into shift_reg; later stat_d changes do not corrupt an in-flight word.
// - Write-then-read of the same ctrl word in one burst is not possible (address advances); a following frame returns the new value.
// - NSS held high: sck and mosi toggling are ignored; no state change.
// - Latency: ctrl_q valid 1 clk after the synchronised last-data sck_rise, i.e. <= 4 clk after the pin edge.
// TESTING
// - Reset: assert rst_b=0 mid-frame -> ctrl_q = CTRL_RST, miso_oe = 0, busy = 0; next frame decodes normally.
// - Write: CMD 0x01, data 0xDEADBEEF.
//   - ctrl word0 = 0xDEADBEEF.
//   - wr_stb = 8'b0000_0001 for 1 clk.
//   - Re-read with CMD 0x81 -> MISO returns 0xDEADBEEF.
// - Read ID: CMD 0x80 with MOSI = 0 -> MISO shifts out 0x19110100, MSB first; no wr_stb.
// - Burst write:
//   - CMD 0x07, then 3 words A, B, C -> ctrl word6 = A, word7 = B.
//   - addr 0x09 is unmapped, so C is dropped.
//   - wr_stb bit6 pulses, then bit7; no other bits.
// - Status burst read with wrap:
//   - Set stat_d = {4,3,2,1}. CMD 0xC2, read 3 words -> 3, 4, 0.
//   - 0x44 is unmapped, so it reads 0.
//   - Changing stat_d mid-word does not alter the word being shifted.
// - Abort: raise NSS after 20 data bits of a write to 0x03 -> ctrl word2 unchanged, no wr_stb, busy = 0 within 4 clk.

Source files
------------

// File: rtl/mcu_spi_regbank_if.sv
// MCU SPI pin bundle shared by the S7 register bank and its master.
// The master drives SCK/NSS/MOSI; the slave returns MISO and its output enable.
interface mcu_spi_regbank_if;
    logic spi_sck;
    logic spi_nss;
    logic spi_mosi;
    logic spi_miso;
    logic spi_miso_oe;

    modport master (
        output spi_sck,
        output spi_nss,
        output spi_mosi,
        input  spi_miso,
        input  spi_miso_oe
    );

    modport slave (
        input  spi_sck,
        input  spi_nss,
        input  spi_mosi,
        output spi_miso,
        output spi_miso_oe
    );
endinterface

// File: rtl/mcu_spi_regbank.sv
// SPI-slave (mode 0) register bank: oversampled pins, framed CMD + burst data words,
// ID word at 0x00, R/W control words at 0x01.., read-only status words at 0x40...
module mcu_spi_regbank #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned NUM_CTRL = 8,
    parameter int unsigned NUM_STAT = 4,
    parameter logic [31:0] ID_WORD  = 32'h1911_0100,
    parameter logic [31:0] CTRL_RST = 32'h0
) (
    input  logic                         clk,
    input  logic                         rst_b,
    mcu_spi_regbank_if.slave             spi,
    output logic [NUM_CTRL*DATA_W-1:0]   ctrl_q,
    output logic [NUM_CTRL-1:0]          wr_stb,
    input  logic [NUM_STAT*DATA_W-1:0]   stat_d,
    output logic                         busy
);

    localparam logic [DATA_W-1:0] IdWord  = ID_WORD[DATA_W-1:0];
    localparam logic [DATA_W-1:0] CtrlRst = CTRL_RST[DATA_W-1:0];
    localparam logic [5:0]        LastBit = 6'(DATA_W - 1);

    typedef enum logic [1:0] {StIdle, StCmd, StData} state_e;

    state_e                       state_q, state_d;
    logic [5:0]                   bit_cnt_q, bit_cnt_d;
    logic [DATA_W-1:0]            shift_q, shift_d;
    logic [6:0]                   addr_q, addr_d;
    logic                         rw_q, rw_d;
    logic                         miso_q, miso_d;
    logic [NUM_CTRL*DATA_W-1:0]   ctrl_r, ctrl_d;
    logic [NUM_CTRL-1:0]          wr_stb_q, wr_stb_d;

    // Two stages for metastability, the third only for edge detection.
    logic [2:0] sck_sync, nss_sync;
    logic [1:0] mosi_sync;

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            sck_sync  <= 3'b000;
            nss_sync  <= 3'b111;
            mosi_sync <= 2'b00;
        end else begin
            sck_sync  <= {sck_sync[1:0], spi.spi_sck};
            nss_sync  <= {nss_sync[1:0], spi.spi_nss};
            mosi_sync <= {mosi_sync[0], spi.spi_mosi};
        end
    end

    logic sck_rise, sck_fall, nss_rise, nss_fall, mosi_bit;
    assign sck_rise = sck_sync[1] & ~sck_sync[2];
    assign sck_fall = ~sck_sync[1] & sck_sync[2];
    assign nss_rise = nss_sync[1] & ~nss_sync[2];
    assign nss_fall = ~nss_sync[1] & nss_sync[2];
    assign mosi_bit = mosi_sync[1];

    logic [DATA_W-1:0] shift_in;
    logic [6:0]        cmd_addr, look_addr;
    logic [DATA_W-1:0] rd_word;

    assign shift_in  = {shift_q[DATA_W-2:0], mosi_bit};
    assign cmd_addr  = {shift_q[5:0], mosi_bit};
    // CMD looks up the start address; DATA pre-fetches the next burst word.
    assign look_addr = (state_q == StCmd) ? cmd_addr : addr_q + 7'd1;

    always_comb begin
        rd_word = '0;
        if (look_addr == 7'h00) rd_word = IdWord;
        for (int unsigned k = 0; k < NUM_CTRL; k++) begin
            if (look_addr == 7'(k + 1)) rd_word = ctrl_r[k*DATA_W +: DATA_W];
        end
        for (int unsigned k = 0; k < NUM_STAT; k++) begin
            if (look_addr == 7'(32'h40 + k)) rd_word = stat_d[k*DATA_W +: DATA_W];
        end
    end

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        addr_d    = addr_q;
        rw_d      = rw_q;
        miso_d    = miso_q;
        ctrl_d    = ctrl_r;
        wr_stb_d  = '0;
        if (nss_rise) begin
            // Deselect wins over any coincident SCK edge; a partial word is dropped.
            state_d   = StIdle;
            bit_cnt_d = '0;
            miso_d    = 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (nss_fall) begin
                        state_d   = StCmd;
                        bit_cnt_d = '0;
                        miso_d    = 1'b0;
                    end
                end
                StCmd: begin
                    if (sck_rise) begin
                        shift_d   = shift_in;
                        bit_cnt_d = bit_cnt_q + 6'd1;
                        if (bit_cnt_q == 6'd7) begin
                            state_d   = StData;
                            bit_cnt_d = '0;
                            rw_d      = shift_q[6];
                            addr_d    = cmd_addr;
                            shift_d   = shift_q[6] ? rd_word : '0;
                        end
                    end
                end
                StData: begin
                    if (sck_fall) begin
                        miso_d = shift_q[DATA_W-1];
                    end else if (sck_rise) begin
                        shift_d   = shift_in;
                        bit_cnt_d = bit_cnt_q + 6'd1;
                        if (bit_cnt_q == LastBit) begin
                            bit_cnt_d = '0;
                            addr_d    = addr_q + 7'd1;
                            if (rw_q) begin
                                shift_d = rd_word;
                            end else begin
                                for (int unsigned k = 0; k < NUM_CTRL; k++) begin
                                    if (addr_q == 7'(k + 1)) begin
                                        ctrl_d[k*DATA_W +: DATA_W] = shift_in;
                                        wr_stb_d[k]                = 1'b1;
                                    end
                                end
                            end
                        end
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q   <= StIdle;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            addr_q    <= '0;
            rw_q      <= 1'b0;
            miso_q    <= 1'b0;
            ctrl_r    <= {NUM_CTRL{CtrlRst}};
            wr_stb_q  <= '0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            addr_q    <= addr_d;
            rw_q      <= rw_d;
            miso_q    <= miso_d;
            ctrl_r    <= ctrl_d;
            wr_stb_q  <= wr_stb_d;
        end
    end

    assign busy            = (state_q != StIdle);
    assign spi.spi_miso_oe = busy;
    assign spi.spi_miso    = miso_q;
    assign ctrl_q          = ctrl_r;
    assign wr_stb          = wr_stb_q;

endmodule

// File: tb/tb_mcu_spi_regbank.sv
// Directed bench for mcu_spi_regbank: a mode-0 SPI master drives frames with hand-computed
// expected register, MISO and strobe values.
module tb_mcu_spi_regbank;

    logic         clk = 1'b0;
    logic         rst_b;
    logic [255:0] ctrl_q;
    logic [7:0]   wr_stb;
    logic [127:0] stat_d;
    logic         busy;

    int nvec = 0;
    int nerr = 0;

    logic [7:0] stb_log[$];

    mcu_spi_regbank_if bus ();

    mcu_spi_regbank dut (
        .clk    (clk),
        .rst_b  (rst_b),
        .spi    (bus.slave),
        .ctrl_q (ctrl_q),
        .wr_stb (wr_stb),
        .stat_d (stat_d),
        .busy   (busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (wr_stb != 8'h00) stb_log.push_back(wr_stb);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] cw(input int k);
        return ctrl_q[k*32 +: 32];
    endfunction

    function automatic logic [7:0] stb_at(input int i);
        return (i < stb_log.size()) ? stb_log[i] : 8'h00;
    endfunction

    // SCK half period of 80 time units = 8 system clocks.
    task automatic spi_bits(input logic [31:0] tx, input int n, output logic [31:0] rx);
        rx = '0;
        for (int i = n - 1; i >= 0; i--) begin
            bus.spi_mosi = tx[i];
            #80;
            bus.spi_sck = 1'b1;
            rx[i] = bus.spi_miso;
            #80;
            bus.spi_sck = 1'b0;
        end
    endtask

    task automatic frame_begin();
        bus.spi_nss = 1'b0;
        #80;
    endtask

    task automatic frame_end();
        #80;
        bus.spi_nss = 1'b1;
        #300;
    endtask

    initial begin
        logic [31:0] rx, hi, lo;
        rst_b        = 1'b0;
        bus.spi_sck  = 1'b0;
        bus.spi_nss  = 1'b1;
        bus.spi_mosi = 1'b0;
        stat_d       = {32'd4, 32'd3, 32'd2, 32'd1};
        #33;
        check("reset_ctrl0", cw(0), 32'h0);
        check("reset_ctrl7", cw(7), 32'h0);
        check("reset_busy", {31'd0, busy}, 32'h0);
        check("reset_oe", {31'd0, bus.spi_miso_oe}, 32'h0);
        check("reset_miso", {31'd0, bus.spi_miso}, 32'h0);
        check("reset_stb", {24'd0, wr_stb}, 32'h0);
        rst_b = 1'b1;
        #100;

        // Read ID
        stb_log.delete();
        frame_begin();
        spi_bits(32'h80, 8, rx);
        check("cmd_miso_zero", rx, 32'h0);
        check("busy_in_frame", {31'd0, busy}, 32'h1);
        check("oe_in_frame", {31'd0, bus.spi_miso_oe}, 32'h1);
        spi_bits(32'h0, 32, rx);
        check("read_id", rx, 32'h1911_0100);
        frame_end();
        check("id_no_stb", stb_log.size(), 32'd0);
        check("idle_oe", {31'd0, bus.spi_miso_oe}, 32'h0);

        // Single write to ctrl word 0
        stb_log.delete();
        frame_begin();
        spi_bits(32'h01, 8, rx);
        spi_bits(32'hDEAD_BEEF, 32, rx);
        frame_end();
        check("wr_ctrl0", cw(0), 32'hDEAD_BEEF);
        check("wr_ctrl1_untouched", cw(1), 32'h0);
        check("wr_stb_cycles", stb_log.size(), 32'd1);
        check("wr_stb_bits", {24'd0, stb_at(0)}, 32'h01);

        frame_begin();
        spi_bits(32'h81, 8, rx);
        spi_bits(32'h0, 32, rx);
        frame_end();
        check("reread_ctrl0", rx, 32'hDEAD_BEEF);

        // Burst write: 0x07, 0x08, then unmapped 0x09
        stb_log.delete();
        frame_begin();
        spi_bits(32'h07, 8, rx);
        spi_bits(32'h1111_2222, 32, rx);
        spi_bits(32'h3333_4444, 32, rx);
        spi_bits(32'h5555_6666, 32, rx);
        frame_end();
        check("burst_ctrl6", cw(6), 32'h1111_2222);
        check("burst_ctrl7", cw(7), 32'h3333_4444);
        check("burst_ctrl0_kept", cw(0), 32'hDEAD_BEEF);
        check("burst_ctrl5_kept", cw(5), 32'h0);
        check("burst_stb_cycles", stb_log.size(), 32'd2);
        check("burst_stb_first", {24'd0, stb_at(0)}, 32'h40);
        check("burst_stb_second", {24'd0, stb_at(1)}, 32'h80);

        // Status burst 0x42.., stat_d disturbed halfway through the second word
        frame_begin();
        spi_bits(32'hC2, 8, rx);
        spi_bits(32'h0, 32, rx);
        check("stat_word2", rx, 32'd3);
        spi_bits(32'h0, 16, hi);
        stat_d = {4{32'hFFFF_FFFF}};
        spi_bits(32'h0, 16, lo);
        check("stat_word3_snapshot", {hi[15:0], lo[15:0]}, 32'd4);
        spi_bits(32'h0, 32, rx);
        check("stat_unmapped_44", rx, 32'h0);
        frame_end();
        stat_d = {32'd4, 32'd3, 32'd2, 32'd1};

        // Address wrap 0x7F -> 0x00
        frame_begin();
        spi_bits(32'hFF, 8, rx);
        spi_bits(32'h0, 32, rx);
        check("wrap_unmapped_7f", rx, 32'h0);
        spi_bits(32'h0, 32, rx);
        check("wrap_id", rx, 32'h1911_0100);
        frame_end();

        // Abort a write to 0x03 after 20 data bits
        stb_log.delete();
        frame_begin();
        spi_bits(32'h03, 8, rx);
        spi_bits(32'h000A_BCDE, 20, rx);
        @(negedge clk);
        bus.spi_nss = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("abort_busy", {31'd0, busy}, 32'h0);
        check("abort_oe", {31'd0, bus.spi_miso_oe}, 32'h0);
        check("abort_miso", {31'd0, bus.spi_miso}, 32'h0);
        #300;
        check("abort_ctrl2", cw(2), 32'h0);
        check("abort_no_stb", stb_log.size(), 32'd0);

        // Reset in the middle of a frame
        frame_begin();
        spi_bits(32'h01, 8, rx);
        spi_bits(32'h0000_0155, 10, rx);
        rst_b = 1'b0;
        #20;
        check("midrst_ctrl0", cw(0), 32'h0);
        check("midrst_ctrl6", cw(6), 32'h0);
        check("midrst_busy", {31'd0, busy}, 32'h0);
        check("midrst_oe", {31'd0, bus.spi_miso_oe}, 32'h0);
        bus.spi_nss = 1'b1;
        #100;
        rst_b = 1'b1;
        #100;
        stb_log.delete();
        frame_begin();
        spi_bits(32'h02, 8, rx);
        spi_bits(32'hCAFE_F00D, 32, rx);
        frame_end();
        check("postrst_ctrl1", cw(1), 32'hCAFE_F00D);
        check("postrst_stb", {24'd0, stb_at(0)}, 32'h02);
        frame_begin();
        spi_bits(32'h82, 8, rx);
        spi_bits(32'h0, 32, rx);
        frame_end();
        check("postrst_read", rx, 32'hCAFE_F00D);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
